// File: rtl/multicycle_stage_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_stage_sequencer
//
// Control sequencer for a five-stage multicycle datapath:
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH.
// Memory accesses wait for MFC. A bounded wait counter raises a sticky
// Mem_Fault, which parks the sequencer in FETCH until Reset.
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   Hold         in   external stall (freezes stage, wait counter, count)
//   NOP_FLAG     in   decoded instruction is a NOP
//   Mem_Access   in   instruction accesses data memory
//   Mem_Write    in   memory access is a write
//   RF_Write_Req in   instruction writes the register file
//   MFC          in   memory function complete
//   Stage        out  current stage code (0..4)
//   IR/PC/RA/RB/RZ/RM/RY_Enable, RF_WRITE  out  register load enables
//   MEM_Read, MEM_Write, MA_Select         out  memory request, addr select
//   Mem_Fault    out  sticky MFC-timeout flag
//   Instr_Count  out  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_stage_sequencer #(
  parameter int STAGE_W     = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int SKIP_EMPTY  = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Hold,
  input  logic               NOP_FLAG,
  input  logic               Mem_Access,
  input  logic               Mem_Write,
  input  logic               RF_Write_Req,
  input  logic               MFC,
  output logic [STAGE_W-1:0] Stage,
  output logic               IR_Enable,
  output logic               PC_Enable,
  output logic               RA_Enable,
  output logic               RB_Enable,
  output logic               RZ_Enable,
  output logic               RM_Enable,
  output logic               RY_Enable,
  output logic               RF_WRITE,
  output logic               MEM_Read,
  output logic               MEM_Write,
  output logic               MA_Select,
  output logic               Mem_Fault,
  output logic [CNT_W-1:0]   Instr_Count
);

  typedef enum logic [STAGE_W-1:0] {
    FETCH     = STAGE_W'(0),
    DECODE    = STAGE_W'(1),
    EXECUTE   = STAGE_W'(2),
    MEMORY    = STAGE_W'(3),
    WRITEBACK = STAGE_W'(4)
  } stage_t;

  // Wait counter is 8 bits wide because the timeout is at most 255.
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  stage_t     stage;
  stage_t     next_stage;
  logic [7:0] wait_cnt;
  logic [7:0] next_wait;
  logic       next_fault;
  logic       retire;

  assign Stage = stage;

  // Next-state and output decode from the current stage and inputs.
  always_comb begin
    IR_Enable  = 1'b0;
    PC_Enable  = 1'b0;
    RA_Enable  = 1'b0;
    RB_Enable  = 1'b0;
    RZ_Enable  = 1'b0;
    RM_Enable  = 1'b0;
    RY_Enable  = 1'b0;
    RF_WRITE   = 1'b0;
    MEM_Read   = 1'b0;
    MEM_Write  = 1'b0;
    MA_Select  = 1'b0;
    next_stage = stage;
    next_wait  = wait_cnt;
    next_fault = Mem_Fault;
    retire     = 1'b0;

    if (Reset) begin
      next_stage = FETCH;
      next_wait  = 8'd0;
    end else if (Mem_Fault) begin
      // Faulted: park in FETCH with every request and enable low.
      next_stage = FETCH;
      next_wait  = 8'd0;
    end else if (Hold && (stage <= WRITEBACK)) begin
      // Stalled: everything frozen, MFC in this cycle is dropped.
      next_stage = stage;
    end else begin
      // Any stage change clears the wait counter; waiting branches override.
      next_wait = 8'd0;
      case (stage)
        FETCH: begin
          MEM_Read  = 1'b1;
          MA_Select = 1'b1;
          if (MFC) begin
            IR_Enable  = 1'b1;
            PC_Enable  = 1'b1;
            next_stage = DECODE;
          end else if (wait_cnt == TIMEOUT) begin
            next_fault = 1'b1;
            next_stage = FETCH;
          end else begin
            next_wait = wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          RA_Enable = 1'b1;
          RB_Enable = 1'b1;
          if (NOP_FLAG) begin
            next_stage = FETCH;
            retire     = 1'b1;
          end else begin
            next_stage = EXECUTE;
          end
        end
        EXECUTE: begin
          RZ_Enable = 1'b1;
          RM_Enable = 1'b1;
          if (Mem_Access || (SKIP_EMPTY == 0)) begin
            next_stage = MEMORY;
          end else if (RF_Write_Req) begin
            next_stage = WRITEBACK;
          end else begin
            next_stage = FETCH;
            retire     = 1'b1;
          end
        end
        MEMORY: begin
          if (Mem_Access) begin
            MEM_Read  = !Mem_Write;
            MEM_Write = Mem_Write;
            if (MFC) begin
              RY_Enable  = 1'b1;
              next_stage = WRITEBACK;
            end else if (wait_cnt == TIMEOUT) begin
              next_fault = 1'b1;
              next_stage = FETCH;
            end else begin
              next_wait = wait_cnt + 8'd1;
            end
          end else begin
            // Empty memory stage: pass the EXECUTE result through RY.
            RY_Enable  = 1'b1;
            next_stage = WRITEBACK;
          end
        end
        WRITEBACK: begin
          RF_WRITE   = RF_Write_Req;
          next_stage = FETCH;
          retire     = 1'b1;
        end
        default: begin
          // Illegal stage code: recover to FETCH with all outputs low.
          next_stage = FETCH;
        end
      endcase
    end
  end

  // Stage, wait counter, fault flag and retirement counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stage       <= FETCH;
      wait_cnt    <= 8'd0;
      Mem_Fault   <= 1'b0;
      Instr_Count <= {CNT_W{1'b0}};
    end else begin
      stage     <= next_stage;
      wait_cnt  <= next_wait;
      Mem_Fault <= next_fault;
      if (retire) begin
        Instr_Count <= Instr_Count + CNT_W'(1);
      end else begin
        Instr_Count <= Instr_Count;
      end
    end
  end

endmodule
